instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/fetch_pc_reg.sv | 20 ++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: fetch FSM states, NOP encoding and base opcodes shared by fetch and control.
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        ERROR
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with +4 incrementer and redirect mux (redirect wins over increment).
module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    assign pc4 = pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pc <= RESET_PC;
        else pc <= load ? target : inc ? pc4 : pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch FSM with a held output slot,
// branch redirect with stale-response dropping, and a sticky misaligned-target error.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        misaligned
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc4;
    logic         drop, drop_n;
    logic         br_ok, br_bad, accept, consume, pending;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (br_ok),
        .inc    (accept),
        .target (br_target),
        .pc     (pc),
        .pc4    (pc4)
    );

    assign br_ok   = br_taken && br_target[1:0] == 2'b00 && state != ERROR;
    assign br_bad  = br_taken && br_target[1:0] != 2'b00 && state != ERROR;
    assign accept  = state == WAIT && imem_rvalid && !drop && !br_taken;
    assign consume = id_valid && id_ready;

    assign imem_req  = state == REQ;
    assign imem_addr = pc;

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign funct7 = id_instr[31:25];
    assign rd     = id_instr[11:7];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    // A response is still owed on redirect if one is being issued now, our own WAIT
    // request has not returned this cycle, or an earlier dropped one is still in flight.
    assign pending = state == REQ || (drop && !imem_rvalid) ||
                     (state == WAIT && (drop || !imem_rvalid));
    assign drop_n  = br_ok ? pending : drop && !imem_rvalid;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = REQ;
            REQ:     state_n = WAIT;
            WAIT:    state_n = accept ? HOLD : WAIT;
            HOLD:    state_n = consume ? REQ : HOLD;
            default: state_n = ERROR;
        endcase
        if (br_ok) state_n = REQ;
        if (br_bad) state_n = ERROR;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            drop       <= 1'b0;
            misaligned <= 1'b0;
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_pc      <= 32'h0;
            id_pc4     <= 32'h0;
        end else begin
            state      <= state_n;
            drop       <= drop_n;
            misaligned <= misaligned || br_bad;
            if (br_ok || br_bad) id_valid <= 1'b0;
            else if (accept) begin
                id_valid <= 1'b1;
                id_instr <= imem_rdata;
                id_pc    <= pc;
                id_pc4   <= pc4;
            end else if (consume) id_valid <= 1'b0;
        end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch, stall, redirect, error, reset and pc-wrap scenarios.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_n_b = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        id_ready = 1'b0;

    logic        imem_req, id_valid, misaligned;
    logic [31:0] imem_addr, id_instr, id_pc, id_pc4;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;

    logic        imem_req_b, id_valid_b, misaligned_b;
    logic [31:0] imem_addr_b, id_instr_b, id_pc_b, id_pc4_b;
    logic [6:0]  opcode_b, funct7_b;
    logic [2:0]  funct3_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .br_taken(br_taken), .br_target(br_target),
        .id_ready(id_ready), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .misaligned(misaligned)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .br_taken(br_taken), .br_target(br_target),
        .id_ready(id_ready), .id_valid(id_valid_b),
        .id_instr(id_instr_b), .id_pc(id_pc_b), .id_pc4(id_pc4_b),
        .opcode(opcode_b), .funct3(funct3_b), .funct7(funct7_b),
        .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b), .misaligned(misaligned_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr", id_instr, 32'h0000_0013);
        check("rst_pc", id_pc, 32'h0);
        check("rst_pc4", id_pc4, 32'h0);
        check("rst_mis", {31'b0, misaligned}, 32'd0);
        check("rst_opcode", {25'b0, opcode}, 32'h13);

        // first fetch after release
        rst_n = 1'b1;
        tick();
        check("f1_req", {31'b0, imem_req}, 32'd1);
        check("f1_addr", imem_addr, 32'h0);
        tick();
        check("f1_wait_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0033;
        tick();
        imem_rvalid = 1'b0;
        check("f1_valid", {31'b0, id_valid}, 32'd1);
        check("f1_instr", id_instr, 32'h0000_0033);
        check("f1_opcode", {25'b0, opcode}, 32'h33);
        check("f1_pc", id_pc, 32'h0);
        check("f1_pc4", id_pc4, 32'h4);

        // stall with id_ready low
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'b0, id_valid}, 32'd1);
            check("stall_instr", id_instr, 32'h0000_0033);
            check("stall_pc", id_pc, 32'h0);
            check("stall_req", {31'b0, imem_req}, 32'd0);
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("f2_req", {31'b0, imem_req}, 32'd1);
        check("f2_addr", imem_addr, 32'h4);
        check("f2_consumed", {31'b0, id_valid}, 32'd0);

        // redirect in WAIT, stale response arrives later
        tick();
        br_taken = 1'b1;
        br_target = 32'h0000_0100;
        tick();
        br_taken = 1'b0;
        check("br1_req", {31'b0, imem_req}, 32'd1);
        check("br1_addr", imem_addr, 32'h100);
        check("br1_valid", {31'b0, id_valid}, 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0BAD_F00D;
        tick();
        check("stale_valid", {31'b0, id_valid}, 32'd0);
        check("stale_req", {31'b0, imem_req}, 32'd0);
        imem_rdata = 32'h4020_F1B3;
        tick();
        imem_rvalid = 1'b0;
        check("br1_valid2", {31'b0, id_valid}, 32'd1);
        check("br1_instr", id_instr, 32'h4020_F1B3);
        check("br1_pc", id_pc, 32'h100);
        check("br1_pc4", id_pc4, 32'h104);
        check("fld_opcode", {25'b0, opcode}, 32'h33);
        check("fld_funct3", {29'b0, funct3}, 32'h7);
        check("fld_funct7", {25'b0, funct7}, 32'h20);
        check("fld_rd", {27'b0, rd}, 32'h3);
        check("fld_rs1", {27'b0, rs1}, 32'h1);
        check("fld_rs2", {27'b0, rs2}, 32'h2);

        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("f3_addr", imem_addr, 32'h104);
        check("f3_req", {31'b0, imem_req}, 32'd1);

        // redirect and response in the same cycle
        tick();
        br_taken = 1'b1;
        br_target = 32'h0000_0200;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        br_taken = 1'b0;
        imem_rvalid = 1'b0;
        check("br2_valid", {31'b0, id_valid}, 32'd0);
        check("br2_req", {31'b0, imem_req}, 32'd1);
        check("br2_addr", imem_addr, 32'h200);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5537;
        tick();
        imem_rvalid = 1'b0;
        check("br2_valid2", {31'b0, id_valid}, 32'd1);
        check("br2_instr", id_instr, 32'h1234_5537);
        check("br2_pc", id_pc, 32'h200);

        // redirect on the same cycle as a consume
        id_ready = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h0000_0300;
        tick();
        id_ready = 1'b0;
        br_taken = 1'b0;
        check("br3_addr", imem_addr, 32'h300);
        check("br3_req", {31'b0, imem_req}, 32'd1);
        check("br3_valid", {31'b0, id_valid}, 32'd0);

        // misaligned redirect locks up until reset
        tick();
        br_taken = 1'b1;
        br_target = 32'h0000_0102;
        tick();
        br_taken = 1'b0;
        check("mis_flag", {31'b0, misaligned}, 32'd1);
        check("mis_valid", {31'b0, id_valid}, 32'd0);
        check("mis_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0033;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("err_req", {31'b0, imem_req}, 32'd0);
            check("err_mis", {31'b0, misaligned}, 32'd1);
            check("err_valid", {31'b0, id_valid}, 32'd0);
        end
        imem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_mis", {31'b0, misaligned}, 32'd0);
        check("arst_instr", id_instr, 32'h0000_0013);
        check("arst_pc", id_pc, 32'h0);
        check("arst_req", {31'b0, imem_req}, 32'd0);

        // reset mid-transaction, late response ignored
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0BAD;
        tick();
        imem_rvalid = 1'b0;
        check("late_req", {31'b0, imem_req}, 32'd1);
        check("late_addr", imem_addr, 32'h0);
        check("late_valid", {31'b0, id_valid}, 32'd0);
        tick();
        tick();
        check("late_valid2", {31'b0, id_valid}, 32'd0);
        check("late_instr", id_instr, 32'h0000_0013);
        rst_n = 1'b0;

        // pc wrap on the second instance
        rst_n_b = 1'b1;
        id_ready = 1'b1;
        tick();
        check("wrap_req", {31'b0, imem_req_b}, 32'd1);
        check("wrap_addr1", imem_addr_b, 32'hFFFF_FFFC);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        check("wrap_valid", {31'b0, id_valid_b}, 32'd1);
        check("wrap_pc", id_pc_b, 32'hFFFF_FFFC);
        check("wrap_pc4", id_pc4_b, 32'h0);
        tick();
        check("wrap_req2", {31'b0, imem_req_b}, 32'd1);
        check("wrap_addr2", imem_addr_b, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
